// File: rtl/cabac_deadlock_reporter.sv
// cabac_deadlock_reporter
//   Consumes the registered block flag and channel info from an AXIS deadlock monitor. A
//   deadlock is confirmed only after TIMEOUT consecutive enabled+blocked cycles, so short
//   stalls are filtered out. On confirmation the channel info is latched. The channels whose
//   latched field is nonzero are then reported one at a time over a valid/ack port, and a
//   one-cycle done pulse follows the last channel. Afterwards the block stays in a terminal
//   state until reset.
// Ports
//   clock, reset    rising-edge clock, synchronous active-high reset
//   enable_i        detection armed
//   block_in_i      monitor block flag
//   block_info_i    monitor info, field k = [k*INFO_W +: INFO_W]
//   report_ack_i    consumer accepts the current report beat
//   deadlock_o      sticky deadlock flag
//   deadlock_info_o block_info_i latched at confirmation
//   stall_cycles_o  consecutive blocked cycles, frozen after confirmation
//   report_valid_o  report beat valid
//   report_ch_o     channel index of the current beat
//   report_field_o  latched field of that channel
//   report_done_o   one-cycle pulse when the report walk finishes
module cabac_deadlock_reporter #(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned INFO_W  = 3,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_i,
    input  logic                     block_in_i,
    input  logic [NUM_CH*INFO_W-1:0] block_info_i,
    input  logic                     report_ack_i,
    output logic                     deadlock_o,
    output logic [NUM_CH*INFO_W-1:0] deadlock_info_o,
    output logic [CNT_W-1:0]         stall_cycles_o,
    output logic                     report_valid_o,
    output logic [CH_W-1:0]          report_ch_o,
    output logic [INFO_W-1:0]        report_field_o,
    output logic                     report_done_o
);

    typedef enum logic [1:0] {StIdle, StWatch, StReport, StDone} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]  LastCh  = CH_W'(NUM_CH - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         stall_q, stall_d;
    logic                     dead_q, dead_d;
    logic [NUM_CH*INFO_W-1:0] info_q, info_d;
    logic [CH_W-1:0]          idx_q, idx_d;
    logic                     done_q, done_d;

    logic [CNT_W-1:0]  stall_inc;
    logic [INFO_W-1:0] cur_field;
    logic              field_nz;
    logic              confirm;

    assign stall_inc = (stall_q == '1) ? stall_q : stall_q + 1'b1;
    assign cur_field = info_q[idx_q*INFO_W +: INFO_W];
    assign field_nz  = (cur_field != '0);

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        dead_d  = dead_q;
        info_d  = info_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        confirm = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable_i && block_in_i) begin
                    if (TIMEOUT == 1) begin
                        confirm = 1'b1;
                    end else begin
                        state_d = StWatch;
                        stall_d = CNT_W'(1);
                    end
                end else begin
                    stall_d = '0;
                end
            end
            StWatch: begin
                // Any gap in enable or block restarts the count from zero.
                if (!enable_i || !block_in_i) begin
                    state_d = StIdle;
                    stall_d = '0;
                end else if (stall_q == LastCnt) begin
                    confirm = 1'b1;
                end else begin
                    stall_d = stall_inc;
                end
            end
            StReport: begin
                // Zero fields are skipped without waiting for an ack.
                if (!field_nz || report_ack_i) begin
                    if (idx_q == LastCh) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase

        if (confirm) begin
            dead_d  = 1'b1;
            info_d  = block_info_i;
            stall_d = stall_inc;
            state_d = StReport;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            stall_q <= '0;
            dead_q  <= 1'b0;
            info_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            dead_q  <= dead_d;
            info_q  <= info_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign deadlock_o      = dead_q;
    assign deadlock_info_o = info_q;
    assign stall_cycles_o  = stall_q;
    assign report_valid_o  = (state_q == StReport) && field_nz;
    assign report_ch_o     = report_valid_o ? idx_q : '0;
    assign report_field_o  = report_valid_o ? cur_field : '0;
    assign report_done_o   = done_q;

endmodule
